fir_stream_ctrl: RTL and testbench
==================================

Name: fir_stream_ctrl

Overview:
- Sequencer in front of the symmetric FIR datapath. Accepts a coefficient stream and a sample stream over valid/ready handshakes.
- Drives the FIR's clear, load, coefficient and sample inputs, and tags FIR outputs with a valid flag aligned to the pipeline latency.
- Owns reconfiguration: drains in-flight results, clears the FIR, reloads COEFF_NUM coefficients, then resumes streaming.

Parameters:
- COEFF_NUM, 6, number of unique taps loaded per configuration.
- COEFF_WIDTH, 8, coefficient width (signed).
- DATA_WIDTH, 12, sample width (signed).
- OUTPUT_WIDTH, 25, FIR result width (signed).
- PIPE_LAT, 4, cycles from sample presented on fir_data to the matching fir_result; must be 1 or more.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-high reset.
- cfg_start  in  1  one-cycle request to (re)load coefficients.
- cfg_valid  in  1  coefficient word valid.
- cfg_ready  out  1  coefficient word accepted when cfg_valid && cfg_ready.
- cfg_data  in  COEFF_WIDTH  signed coefficient.
- s_valid  in  1  input sample valid.
- s_ready  out  1  sample accepted when s_valid && s_ready.
- s_data  in  DATA_WIDTH  signed input sample.
- fir_clr  out  1  synchronous clear to the FIR.
- fir_load  out  1  coefficient load strobe to the FIR.
- fir_coeff  out  COEFF_WIDTH  coefficient to the FIR.
- fir_data  out  DATA_WIDTH  sample to the FIR.
- fir_result  in  OUTPUT_WIDTH  FIR output.
- m_valid  out  1  m_data holds the result of an accepted sample.
- m_data  out  OUTPUT_WIDTH  equals fir_result (combinational passthrough).
- busy  out  1  high in every state except RUN and IDLE.
- coeff_ok  out  1  a complete coefficient set is loaded.

Behaviour:
- Reset values: state IDLE; fir_clr=1; fir_load=0; fir_coeff=0; fir_data=0; valid shift register all 0; m_valid=0; coeff_ok=0; cfg_ready=0; s_ready=0; counters 0.
- All outputs except m_data, cfg_ready and s_ready are registered. cfg_ready and s_ready decode from the state only.
- FSM states are IDLE, DRAIN, CLEAR, LOAD and RUN.
- IDLE:
  - cfg_ready=0, s_ready=0, fir_clr=0.
  - cfg_start moves to CLEAR.
- RUN:
  - s_ready=1 every cycle.
  - Each edge registers fir_data <= (s_valid ? s_data : 0) and shifts s_valid into the valid shift register vld[0].
  - A cycle without s_valid is a zero bubble; its result is not flagged.
  - cfg_start moves to DRAIN.
- DRAIN:
  - s_ready=0; fir_data <= 0; a 0 is shifted into vld.
  - Stays exactly PIPE_LAT cycles, then moves to CLEAR.
  - Every sample accepted before DRAIN still gets m_valid.
- CLEAR:
  - One cycle with fir_clr=1, vld flushed to 0 and coeff_ok <= 0. Then moves to LOAD.
- LOAD:
  - cfg_ready=1.
  - Each handshake registers fir_coeff <= cfg_data and fir_load <= 1; otherwise fir_load <= 0.
  - coeff_cnt increments per accepted word. On the COEFF_NUM-th accept: coeff_ok <= 1, coeff_cnt <= 0, and the next state is RUN.
  - cfg_valid gaps stall the load without timeout. fir_load must not stay high across gaps.
- m_valid = vld[PIPE_LAT-1], so m_valid is high exactly PIPE_LAT cycles after the matching fir_data register update.
- cfg_start is ignored in DRAIN, CLEAR and LOAD. Extra cfg_valid words outside LOAD are not accepted (cfg_ready=0).
- cfg_start and s_valid in the same RUN cycle: that sample is accepted, then the FSM moves to DRAIN.
- clr asserted mid-LOAD or mid-DRAIN: the block returns to reset values immediately. Partial coefficients are discarded and coeff_ok=0.
- No arithmetic in this block. Widths pass through unchanged, and fir_data is zero-filled on bubbles.

Decomposition:
- Shared package fir_pkg holds:
  - the state enum (IDLE, DRAIN, CLEAR, LOAD, RUN);
  - default width constants COEFF_WIDTH=8, DATA_WIDTH=12, OUTPUT_WIDTH=25, PIPE_LAT=4;
  - the function deriving OUTPUT_WIDTH from DATA_WIDTH and COEFF_WIDTH (DATA+1, +COEFF+1, +1, +2).
- One sub-module, fir_valid_pipe: a PIPE_LAT-deep shift register with synchronous flush and asynchronous clr, instantiated for vld.
- A top-level integration wrapper instantiates fir_stream_ctrl plus symmetricFIR. It is out of scope here.

Test Plan:
- Reset, then cfg_start. Expect CLEAR for 1 cycle with fir_clr=1. Send coefficients 1,-2,3,-4,5,-6 back-to-back. Expect fir_load high 6 consecutive cycles with fir_coeff in that order, then coeff_ok=1 and RUN.
- Send the same coefficients with cfg_valid low every other cycle. Expect fir_load to pulse only on accepts (6 pulses total) and coeff_ok to rise after the 6th.
- In RUN, send samples 0x100, bubble, 0x7FF. Expect fir_data sequence 0x100, 0x000, 0x7FF and m_valid pattern 1,0,1 starting exactly 4 cycles after the first fir_data update.
- Assert cfg_start together with s_valid (0x055) while 3 earlier samples are in flight. Expect 0x055 accepted, s_ready=0 for 4 DRAIN cycles, all 4 pending m_valid pulses seen, then fir_clr=1 for 1 cycle and cfg_ready=1.
- Assert clr after 3 of 6 coefficients are loaded. Expect immediate IDLE, coeff_ok=0 and fir_load=0. A subsequent cfg_start requires all 6 words again.
- Drive cfg_valid=1 in IDLE and cfg_start during LOAD. Expect cfg_ready=0 in IDLE, no extra fir_load, and no state change from the cfg_start.

Source files
------------

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared types and constants for the FIR stream sequencer.
//                Holds the controller state encoding, the default widths
//                and the helper that derives the FIR result width from the
//                sample and coefficient widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

   localparam int FIR_COEFF_NUM   = 6;
   localparam int FIR_COEFF_WIDTH = 8;
   localparam int FIR_DATA_WIDTH  = 12;
   localparam int FIR_PIPE_LAT    = 4;

   // Result width of the symmetric FIR:
   // pre-adder (+1), multiplier (+COEFF+1), final add (+1), tap accumulation (+2).
   function automatic int fir_out_width(input int data_w, input int coeff_w);
      return (data_w + 1) + (coeff_w + 1) + 1 + 2;
   endfunction

   localparam int FIR_OUTPUT_WIDTH = fir_out_width(FIR_DATA_WIDTH, FIR_COEFF_WIDTH);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DRAIN = 3'd1,
      CLEAR = 3'd2,
      LOAD  = 3'd3,
      RUN   = 3'd4
   } fir_state_t;

endpackage
`default_nettype wire

// File: rtl/fir_valid_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fir_valid_pipe
//  Description : DEPTH-deep single-bit shift register that tracks which FIR
//                pipeline slots carry a real sample. A synchronous flush
//                empties every stage at once.
//  Ports       : clk   - system clock, rising edge
//                clr   - asynchronous active-high reset
//                flush - synchronous clear of all stages
//                din   - bit shifted into stage 0
//                dout  - last stage (stage DEPTH-1)
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_valid_pipe #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic clr,
   input  logic flush,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] vld_q;
   logic [DEPTH-1:0] vld_d;

   // A single-stage pipe has no lower slice to shift from.
   generate
      if (DEPTH == 1) begin : g_single
         always_comb begin
            vld_d = flush ? 1'b0 : din;
         end
      end else begin : g_shift
         always_comb begin
            vld_d = flush ? '0 : {vld_q[DEPTH-2:0], din};
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         vld_q <= '0;
      end else begin
         vld_q <= vld_d;
      end
   end

   assign dout = vld_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/fir_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fir_stream_ctrl
//  Description : Sequencer in front of the symmetric FIR datapath. Loads a
//                coefficient set over a valid/ready stream, feeds samples to
//                the FIR (zero bubbles when no sample), flags results with a
//                valid aligned to the FIR latency, and on reconfiguration
//                drains, clears and reloads the filter.
//  Ports       : clk, clr              - clock / async active-high reset
//                cfg_start             - request to (re)load coefficients
//                cfg_valid/ready/data  - coefficient stream
//                s_valid/ready/data    - sample stream
//                fir_clr/load/coeff/data - controls and operands to the FIR
//                fir_result            - FIR output
//                m_valid/m_data        - flagged result stream
//                busy                  - not in RUN or IDLE
//                coeff_ok              - full coefficient set loaded
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_stream_ctrl
   import fir_pkg::*;
#(
   parameter int COEFF_NUM    = FIR_COEFF_NUM,
   parameter int COEFF_WIDTH  = FIR_COEFF_WIDTH,
   parameter int DATA_WIDTH   = FIR_DATA_WIDTH,
   parameter int OUTPUT_WIDTH = FIR_OUTPUT_WIDTH,
   parameter int PIPE_LAT     = FIR_PIPE_LAT
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic                    cfg_start,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [COEFF_WIDTH-1:0]  cfg_data,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [DATA_WIDTH-1:0]   s_data,
   output logic                    fir_clr,
   output logic                    fir_load,
   output logic [COEFF_WIDTH-1:0]  fir_coeff,
   output logic [DATA_WIDTH-1:0]   fir_data,
   input  logic [OUTPUT_WIDTH-1:0] fir_result,
   output logic                    m_valid,
   output logic [OUTPUT_WIDTH-1:0] m_data,
   output logic                    busy,
   output logic                    coeff_ok
);

   localparam int CNT_W = (COEFF_NUM > 1) ? $clog2(COEFF_NUM) : 1;
   localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [CNT_W-1:0] C_COEFF_LAST = CNT_W'(COEFF_NUM - 1);
   localparam logic [DRN_W-1:0] C_DRAIN_LAST = DRN_W'(PIPE_LAT - 1);

   fir_state_t              state_q, state_d;
   logic [CNT_W-1:0]        coeff_cnt_q, coeff_cnt_d;
   logic [DRN_W-1:0]        drain_cnt_q, drain_cnt_d;
   logic                    fir_clr_q, fir_clr_d;
   logic                    fir_load_q, fir_load_d;
   logic [COEFF_WIDTH-1:0]  fir_coeff_q, fir_coeff_d;
   logic [DATA_WIDTH-1:0]   fir_data_q, fir_data_d;
   logic                    m_valid_q, m_valid_d;
   logic                    coeff_ok_q, coeff_ok_d;
   logic                    busy_q, busy_d;

   logic                    w_cfg_fire;
   logic                    w_vld_in;
   logic                    w_vld_flush;
   logic                    w_vld_last;

   // Handshake readiness depends only on the current state.
   assign cfg_ready  = (state_q == LOAD);
   assign s_ready    = (state_q == RUN);
   assign w_cfg_fire = cfg_valid && (state_q == LOAD);

   // ------------------------------------------------------------------
   // State register and all registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q     <= IDLE;
         coeff_cnt_q <= '0;
         drain_cnt_q <= '0;
         fir_clr_q   <= 1'b1;
         fir_load_q  <= 1'b0;
         fir_coeff_q <= '0;
         fir_data_q  <= '0;
         m_valid_q   <= 1'b0;
         coeff_ok_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         coeff_cnt_q <= coeff_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         fir_clr_q   <= fir_clr_d;
         fir_load_q  <= fir_load_d;
         fir_coeff_q <= fir_coeff_d;
         fir_data_q  <= fir_data_d;
         m_valid_q   <= m_valid_d;
         coeff_ok_q  <= coeff_ok_d;
         busy_q      <= busy_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cfg_start) state_d = CLEAR;
         RUN:     if (cfg_start) state_d = DRAIN;
         DRAIN:   if (drain_cnt_q == C_DRAIN_LAST) state_d = CLEAR;
         CLEAR:   state_d = LOAD;
         LOAD:    if (w_cfg_fire && (coeff_cnt_q == C_COEFF_LAST)) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Output / datapath next values
   // ------------------------------------------------------------------
   always_comb begin
      coeff_cnt_d = coeff_cnt_q;
      drain_cnt_d = '0;
      fir_load_d  = 1'b0;
      fir_coeff_d = fir_coeff_q;
      fir_data_d  = '0;
      coeff_ok_d  = coeff_ok_q;
      w_vld_in    = 1'b0;
      w_vld_flush = 1'b0;

      case (state_q)
         RUN: begin
            // Bubbles feed zeros so the FIR sees a clean stream.
            fir_data_d = s_valid ? s_data : '0;
            w_vld_in   = s_valid;
         end
         DRAIN: begin
            drain_cnt_d = (drain_cnt_q == C_DRAIN_LAST) ? '0 : drain_cnt_q + 1'b1;
         end
         CLEAR: begin
            w_vld_flush = 1'b1;
            coeff_ok_d  = 1'b0;
            coeff_cnt_d = '0;
         end
         LOAD: begin
            if (w_cfg_fire) begin
               fir_coeff_d = cfg_data;
               fir_load_d  = 1'b1;
               if (coeff_cnt_q == C_COEFF_LAST) begin
                  coeff_cnt_d = '0;
                  coeff_ok_d  = 1'b1;
               end else begin
                  coeff_cnt_d = coeff_cnt_q + 1'b1;
               end
            end
         end
         default: begin
         end
      endcase

      // Registered state decodes look at the upcoming state so they line
      // up with the cycle that state is actually occupied.
      fir_clr_d = (state_d == CLEAR);
      busy_d    = (state_d != RUN) && (state_d != IDLE);
      // One extra register behind the PIPE_LAT-deep tracker matches the
      // registered fir_data hop, giving exactly PIPE_LAT cycles of latency.
      m_valid_d = w_vld_last;
   end

   fir_valid_pipe #(
      .DEPTH (PIPE_LAT)
   ) u_vld (
      .clk   (clk),
      .clr   (clr),
      .flush (w_vld_flush),
      .din   (w_vld_in),
      .dout  (w_vld_last)
   );

   assign fir_clr   = fir_clr_q;
   assign fir_load  = fir_load_q;
   assign fir_coeff = fir_coeff_q;
   assign fir_data  = fir_data_q;
   assign m_valid   = m_valid_q;
   assign m_data    = fir_result;
   assign busy      = busy_q;
   assign coeff_ok  = coeff_ok_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_stream_ctrl
//  Description : Directed self-checking bench for fir_stream_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_stream_ctrl;

   logic        clk;
   logic        clr;
   logic        cfg_start;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [7:0]  cfg_data;
   logic        s_valid;
   logic        s_ready;
   logic [11:0] s_data;
   logic        fir_clr;
   logic        fir_load;
   logic [7:0]  fir_coeff;
   logic [11:0] fir_data;
   logic [24:0] fir_result;
   logic        m_valid;
   logic [24:0] m_data;
   logic        busy;
   logic        coeff_ok;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] coef [6];

   fir_stream_ctrl #(
      .COEFF_NUM    (6),
      .COEFF_WIDTH  (8),
      .DATA_WIDTH   (12),
      .OUTPUT_WIDTH (25),
      .PIPE_LAT     (4)
   ) dut (
      .clk        (clk),
      .clr        (clr),
      .cfg_start  (cfg_start),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_data   (cfg_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .fir_clr    (fir_clr),
      .fir_load   (fir_load),
      .fir_coeff  (fir_coeff),
      .fir_data   (fir_data),
      .fir_result (fir_result),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .busy       (busy),
      .coeff_ok   (coeff_ok)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      coef = '{8'h01, 8'hFE, 8'h03, 8'hFC, 8'h05, 8'hFA};
      clr = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
      s_valid = 1'b0; s_data = '0; fir_result = 25'h1A5A5A5;

      // ---------------- reset values ----------------
      step(); step();
      chk("rst_fir_clr",   32'(fir_clr),   32'd1);
      chk("rst_fir_load",  32'(fir_load),  32'd0);
      chk("rst_fir_coeff", 32'(fir_coeff), 32'd0);
      chk("rst_fir_data",  32'(fir_data),  32'd0);
      chk("rst_m_valid",   32'(m_valid),   32'd0);
      chk("rst_coeff_ok",  32'(coeff_ok),  32'd0);
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
      chk("rst_s_ready",   32'(s_ready),   32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("m_data_pass",   32'(m_data),    32'h1A5A5A5);

      clr = 1'b0;
      step();
      chk("idle_fir_clr", 32'(fir_clr), 32'd0);

      // ---------------- cfg_valid in IDLE is not accepted ----------------
      cfg_valid = 1'b1; cfg_data = 8'h33;
      chk("idle_cfg_ready", 32'(cfg_ready), 32'd0);
      step();
      chk("idle_no_load", 32'(fir_load), 32'd0);
      chk("idle_busy",    32'(busy),     32'd0);
      cfg_valid = 1'b0;

      // ---------------- first load, back-to-back ----------------
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      chk("clear_fir_clr",   32'(fir_clr),   32'd1);
      chk("clear_busy",      32'(busy),      32'd1);
      chk("clear_cfg_ready", 32'(cfg_ready), 32'd0);
      step();
      chk("load_fir_clr",   32'(fir_clr),   32'd0);
      chk("load_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("load_coeff_ok",  32'(coeff_ok),  32'd0);
      for (int i = 0; i < 6; i++) begin
         cfg_valid = 1'b1; cfg_data = coef[i];
         step();
         chk($sformatf("b2b_load%0d", i),  32'(fir_load),  32'd1);
         chk($sformatf("b2b_coeff%0d", i), 32'(fir_coeff), 32'(coef[i]));
         chk($sformatf("b2b_ok%0d", i),    32'(coeff_ok),  (i == 5) ? 32'd1 : 32'd0);
      end
      cfg_valid = 1'b0;
      chk("run_s_ready",   32'(s_ready),   32'd1);
      chk("run_cfg_ready", 32'(cfg_ready), 32'd0);
      step();
      chk("run_load_low", 32'(fir_load), 32'd0);
      chk("run_busy",     32'(busy),     32'd0);

      // ---------------- samples with a bubble ----------------
      s_valid = 1'b1; s_data = 12'h100;
      step();
      chk("smp0_data",  32'(fir_data), 32'h100);
      chk("smp0_mv",    32'(m_valid),  32'd0);
      s_valid = 1'b0; s_data = 12'h3AB;
      step();
      chk("bubble_data", 32'(fir_data), 32'h000);
      s_valid = 1'b1; s_data = 12'h7FF;
      step();
      chk("smp2_data", 32'(fir_data), 32'h7FF);
      s_valid = 1'b0;
      step();
      chk("lat_mv_early", 32'(m_valid), 32'd0);
      step();
      chk("lat_mv1", 32'(m_valid), 32'd1);
      step();
      chk("lat_mv0", 32'(m_valid), 32'd0);
      step();
      chk("lat_mv2", 32'(m_valid), 32'd1);
      step();
      chk("lat_mv_end", 32'(m_valid), 32'd0);

      // ---------------- reconfigure with samples in flight ----------------
      s_valid = 1'b1; s_data = 12'h011;
      step();
      s_data = 12'h022;
      step();
      s_data = 12'h033;
      step();
      s_data = 12'h055; cfg_start = 1'b1;
      step();
      cfg_start = 1'b0; s_data = 12'h0AA;
      chk("drn_accept",  32'(fir_data), 32'h055);
      chk("drn_s_ready", 32'(s_ready),  32'd0);
      chk("drn_busy",    32'(busy),     32'd1);
      chk("drn_mv_pre",  32'(m_valid),  32'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("drn_mv%0d", k),     32'(m_valid),  32'd1);
         chk($sformatf("drn_data%0d", k),   32'(fir_data), 32'd0);
         chk($sformatf("drn_sready%0d", k), 32'(s_ready),  32'd0);
         chk($sformatf("drn_clr%0d", k),    32'(fir_clr),  (k == 3) ? 32'd1 : 32'd0);
      end
      s_valid = 1'b0;
      step();
      chk("rcfg_fir_clr",   32'(fir_clr),   32'd0);
      chk("rcfg_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("rcfg_coeff_ok",  32'(coeff_ok),  32'd0);
      chk("rcfg_mv",        32'(m_valid),   32'd0);

      // ---------------- clr during partial load ----------------
      for (int i = 0; i < 3; i++) begin
         cfg_valid = 1'b1; cfg_data = coef[i];
         step();
         chk($sformatf("part_load%0d", i), 32'(fir_load), 32'd1);
      end
      cfg_valid = 1'b0;
      clr = 1'b1;
      #1;
      chk("aclr_fir_load",  32'(fir_load),  32'd0);
      chk("aclr_coeff_ok",  32'(coeff_ok),  32'd0);
      chk("aclr_cfg_ready", 32'(cfg_ready), 32'd0);
      chk("aclr_fir_clr",   32'(fir_clr),   32'd1);
      chk("aclr_fir_coeff", 32'(fir_coeff), 32'd0);
      step();
      clr = 1'b0;
      step();

      // ---------------- gapped reload, cfg_start during LOAD ----------------
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      step();
      chk("gap_cfg_ready", 32'(cfg_ready), 32'd1);
      for (int i = 0; i < 6; i++) begin
         cfg_valid = 1'b1; cfg_data = coef[i];
         cfg_start = (i == 2);
         step();
         chk($sformatf("gap_load%0d", i),  32'(fir_load),  32'd1);
         chk($sformatf("gap_coeff%0d", i), 32'(fir_coeff), 32'(coef[i]));
         cfg_valid = 1'b0; cfg_start = 1'b0; cfg_data = 8'h77;
         step();
         chk($sformatf("gap_noload%0d", i), 32'(fir_load), 32'd0);
         chk($sformatf("gap_ok%0d", i),     32'(coeff_ok), (i == 5) ? 32'd1 : 32'd0);
         chk($sformatf("gap_rdy%0d", i),    32'(cfg_ready), (i == 5) ? 32'd0 : 32'd1);
      end
      chk("gap_run", 32'(s_ready), 32'd1);
      chk("gap_busy", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
